score_collector: RTL and testbench
==================================

SCORE_COLLECTOR -- requirements
Module: score_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each score.
REQ-002 SHALL have parameter N_SCORES, fixed at 10, number of output-layer scores per frame; other values are not supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, the upstream score beat is valid.
REQ-006 SHALL have port in_ready, output, 1, the block can accept a beat.
REQ-007 SHALL have port in_data, input, DATA_W, one unsigned score.
REQ-008 SHALL have port in_first, input, 1, marks the beat as score 0 of a frame.
REQ-009 SHALL have ports score1..score10, output, DATA_W each, parallel frame registers; score(k+1) holds beat k.
REQ-010 SHALL have port out_valid, output, 1, a complete frame is on score1..score10.
REQ-011 SHALL have port out_ready, input, 1, the downstream argmax stage accepts the frame.
REQ-012 SHALL have port count, output, 4, number of beats stored in the current partial frame, 0..9.
REQ-013 SHALL have port sync_err, output, 1, a one-cycle pulse flagging a frame resync.

Function
REQ-014 SHALL implement two states: FILL and FULL.
REQ-015 in_ready SHALL be 1 in FILL and 0 in FULL, driven from state only, with no combinational path from any input.
REQ-016 A beat SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1.
REQ-017 In FILL, an accepted beat with in_first=0 SHALL write in_data to slot count and increment count.
REQ-018 In FILL, an accepted beat with in_first=1 SHALL write slot 0 and set count to 1, discarding any partial frame.
REQ-019 sync_err SHALL pulse high for exactly one cycle, the cycle after the edge, when a beat is accepted with in_first=1 and count!=0.
REQ-020 An accepted beat at count=9 SHALL write slot 9, set count to 0, enter FULL, and set out_valid=1 after the same edge (0-cycle latency after the 10th beat).
REQ-021 If that 10th beat has in_first=1, REQ-018 SHALL take priority: slot 0 is written, count becomes 1, the block stays in FILL, and sync_err pulses.
REQ-022 In FULL, score1..score10 SHALL hold stable, and in_valid and in_first SHALL be ignored.
REQ-023 In FULL, out_valid=1 with out_ready=1 at an edge SHALL return the block to FILL with out_valid=0.
REQ-024 out_valid SHALL NOT drop without out_ready (no retraction).
REQ-025 Score registers SHALL NOT be cleared on handoff; each slot SHALL keep its last value until overwritten.
REQ-026 Data SHALL be stored verbatim, with no arithmetic, truncation or saturation.
REQ-027 out_ready SHALL be ignored while out_valid=0.

Reset
REQ-028 rst=1 at an edge SHALL force state FILL and set count=0, out_valid=0, sync_err=0, and score1..score10=0.
REQ-029 rst SHALL override any simultaneous beat or handoff.
REQ-030 Reset mid-frame SHALL discard the partial frame, and the next accepted beat SHALL go to slot 0.

Verification
REQ-031 Reset, then 10 beats 1..10 back-to-back with in_first on the first beat -> after the 10th edge, score1..score10=1..10, out_valid=1, in_ready=0, count=0, sync_err never 1.
REQ-032 Full frame, out_ready held 0 for 5 cycles while in_valid=1 with data 0xFF -> outputs unchanged and out_valid=1 throughout; out_ready=1 -> out_valid=0 and in_ready=1 the next cycle.
REQ-033 4 beats 0x11..0x14, then a beat 0x55 with in_first=1, then 9 beats -> sync_err is a single pulse after the 0x55 edge, and score1=0x55.
REQ-034 in_valid toggling 1,0,1,0 across a 10-beat frame -> only beats with in_valid=1 are counted, and count increments by one per accepted beat.
REQ-035 rst=1 after 7 beats -> count=0 and all scores 0; the next frame 10..100 step 10 -> score1=10, score10=100.
REQ-036 10th beat coinciding with in_first=1 -> out_valid stays 0, count=1, sync_err pulses once.

Source files
------------

// File: rtl/score_collector.sv
// score_collector: gathers one frame of serial output-layer scores into parallel registers for the argmax stage.
module score_collector #(
    parameter int DATA_W   = 8,
    parameter int N_SCORES = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_first,
    output logic [DATA_W-1:0] score1,
    output logic [DATA_W-1:0] score2,
    output logic [DATA_W-1:0] score3,
    output logic [DATA_W-1:0] score4,
    output logic [DATA_W-1:0] score5,
    output logic [DATA_W-1:0] score6,
    output logic [DATA_W-1:0] score7,
    output logic [DATA_W-1:0] score8,
    output logic [DATA_W-1:0] score9,
    output logic [DATA_W-1:0] score10,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        count,
    output logic              sync_err
);
    typedef enum logic {FILL, FULL} state_t;

    state_t            r_state, w_state_nx;
    logic [3:0]        r_count, w_count_nx, w_slot;
    logic              r_sync_err, w_sync_nx, w_accept;
    logic [DATA_W-1:0] r_score [N_SCORES];

    // A first-marked beat always restarts the frame, even when it would be the 10th.
    always_comb begin
        w_accept   = (r_state == FILL) && in_valid;
        w_slot     = in_first ? 4'd0 : r_count;
        w_sync_nx  = w_accept && in_first && (r_count != 4'd0);
        w_count_nx = r_count;
        w_state_nx = r_state;
        if (r_state == FILL) begin
            if (w_accept) begin
                w_count_nx = in_first ? 4'd1 : (r_count == 4'd9 ? 4'd0 : r_count + 4'd1);
                w_state_nx = (!in_first && r_count == 4'd9) ? FULL : FILL;
            end
        end else begin
            w_state_nx = out_ready ? FILL : FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FILL;
            r_count    <= 4'd0;
            r_sync_err <= 1'b0;
            for (int k = 0; k < N_SCORES; k++) r_score[k] <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_count    <= w_count_nx;
            r_sync_err <= w_sync_nx;
            if (w_accept) r_score[w_slot] <= in_data;
        end
    end

    assign in_ready  = (r_state == FILL);
    assign out_valid = (r_state == FULL);
    assign count     = r_count;
    assign sync_err  = r_sync_err;
    assign score1    = r_score[0];
    assign score2    = r_score[1];
    assign score3    = r_score[2];
    assign score4    = r_score[3];
    assign score5    = r_score[4];
    assign score6    = r_score[5];
    assign score7    = r_score[6];
    assign score8    = r_score[7];
    assign score9    = r_score[8];
    assign score10   = r_score[9];
endmodule

// File: tb/tb_score_collector.sv
// tb_score_collector: directed and random stimulus against a queue-based frame model.
module tb_score_collector;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_first = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, out_valid, sync_err;
    logic [3:0] count;
    logic [7:0] score1, score2, score3, score4, score5, score6, score7, score8, score9, score10;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] m_partial [$];
    logic [7:0] m_slot [10];
    logic       m_full = 1'b0;
    logic       m_serr = 1'b0;

    score_collector #(.DATA_W(8), .N_SCORES(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_first(in_first),
        .score1(score1), .score2(score2), .score3(score3), .score4(score4), .score5(score5),
        .score6(score6), .score7(score7), .score8(score8), .score9(score9), .score10(score10),
        .out_valid(out_valid), .out_ready(out_ready), .count(count), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        m_serr = 1'b0;
        if (rst) begin
            m_partial.delete();
            m_full = 1'b0;
            foreach (m_slot[k]) m_slot[k] = 8'h00;
        end else if (m_full) begin
            if (out_ready) m_full = 1'b0;
        end else if (in_valid) begin
            if (in_first) begin
                m_serr = (m_partial.size() != 0);
                m_partial.delete();
            end
            m_partial.push_back(in_data);
            m_slot[m_partial.size() - 1] = in_data;
            if (m_partial.size() == 10) begin
                m_full = 1'b1;
                m_partial.delete();
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] sc [10];
        sc = '{score1, score2, score3, score4, score5, score6, score7, score8, score9, score10};
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_full));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_full));
        chk({tag, ".count"}, 32'(count), 32'(m_partial.size()));
        chk({tag, ".sync_err"}, 32'(sync_err), 32'(m_serr));
        for (int k = 0; k < 10; k++) chk($sformatf("%s.score%0d", tag, k + 1), 32'(sc[k]), 32'(m_slot[k]));
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic f,
                        input logic [7:0] d, input logic ordy);
        rst = r; in_valid = v; in_first = f; in_data = d; out_ready = ordy;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        foreach (m_slot[k]) m_slot[k] = 8'h00;
        step("reset", 1, 1, 1, 8'hAA, 1);
        step("reset2", 1, 0, 0, 8'h00, 0);
        // 10 back-to-back beats 1..10
        for (int i = 1; i <= 10; i++) step("frame1", 0, 1, i == 1, 8'(i), 0);
        chk("frame1.score10_const", 32'(score10), 32'd10);
        chk("frame1.full_const", 32'(out_valid), 32'd1);
        // held frame under backpressure while upstream pushes 0xFF
        for (int i = 0; i < 5; i++) step("hold", 0, 1, i[0], 8'hFF, 0);
        step("handoff", 0, 1, 0, 8'hFF, 1);
        chk("handoff.in_ready_const", 32'(in_ready), 32'd1);
        // resync mid-frame
        for (int i = 0; i < 4; i++) step("pre_sync", 0, 1, i == 0, 8'(8'h11 + i), 0);
        step("sync", 0, 1, 1, 8'h55, 0);
        chk("sync.pulse_const", 32'(sync_err), 32'd1);
        for (int i = 0; i < 9; i++) step("post_sync", 0, 1, 0, 8'(8'h60 + i), 0);
        chk("post_sync.score1_const", 32'(score1), 32'h55);
        step("handoff2", 0, 0, 0, 8'h00, 1);
        // in_valid toggling
        for (int i = 0; i < 20; i++) step("toggle", 0, !i[0], i == 0, 8'(8'h30 + i), 0);
        step("handoff3", 0, 0, 0, 8'h00, 1);
        // reset mid-frame then 10..100
        for (int i = 0; i < 7; i++) step("pre_rst", 0, 1, i == 0, 8'(8'h70 + i), 0);
        step("mid_rst", 1, 1, 0, 8'hEE, 1);
        for (int i = 1; i <= 10; i++) step("after_rst", 0, 1, 0, 8'(10 * i), 0);
        chk("after_rst.score1_const", 32'(score1), 32'd10);
        chk("after_rst.score10_const", 32'(score10), 32'd100);
        step("handoff4", 0, 0, 0, 8'h00, 1);
        // 10th beat carries in_first
        for (int i = 0; i < 9; i++) step("pre_tenth", 0, 1, i == 0, 8'(8'h90 + i), 0);
        step("tenth_first", 0, 1, 1, 8'hC3, 0);
        chk("tenth_first.count_const", 32'(count), 32'd1);
        step("tenth_after", 0, 0, 0, 8'h00, 0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 11) == 0), 8'($urandom), $urandom_range(0, 1) == 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
